// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   SPI mode-0 slave that turns 16-bit host frames into single-cycle register
//   file accesses. Frame layout (MSB first): [15] R/W (1 = write),
//   [14] don't care, [13:8] address, [7:0] write data or read data on MISO.
//   The SPI pins are oversampled in the system clock domain; sclk edges are
//   found on the synchronized copy only.
//
// Ports
//   clock, reset_n       system clock, asynchronous active-low reset
//   spi_sclk/cs_n/mosi   host SPI inputs, asynchronous to clock
//   spi_miso, spi_miso_oe  data to host and its output enable
//   address[5:0]         register address, holds between frames
//   write_en, wr_data    one-cycle write strobe with its data
//   read_en, rd_data     one-cycle read strobe; rd_data valid the cycle after
//   frame_err            one-cycle pulse when cs_n rises mid-frame
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [5:0] address,
  output logic       write_en,
  output logic [7:0] wr_data,
  output logic       read_en,
  input  logic [7:0] rd_data,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE, CMD, RD_REQ, RD_LOAD, DATA, WR_STB, DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall;

  state_t      state;
  logic [4:0]  bit_cnt;   // fifth bit is needed to hold the saturated value 16
  logic [7:0]  rx;
  logic [7:0]  tx;
  logic [7:0]  rx_next;
  logic        is_wr;

  // Synchronizer stage: SPI pins into the clock domain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // cs_sync and cs_d both clear to 0, so a cs_n held low through reset never
  // looks like a falling edge: a new frame needs cs_n to go high first.
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;

  // Byte as it will look after the current rising edge is shifted in; used
  // to act on the 8th/16th bit in the same cycle the edge is seen.
  assign rx_next = {rx[6:0], mosi_s};

  assign spi_miso = tx[7];

  // Frame state machine
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx          <= '0;
      tx          <= '0;
      is_wr       <= 1'b0;
      address     <= '0;
      wr_data     <= '0;
      write_en    <= 1'b0;
      read_en     <= 1'b0;
      frame_err   <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      write_en  <= 1'b0;
      read_en   <= 1'b0;
      frame_err <= 1'b0;

      if ((state != IDLE) && (state != DONE) && sclk_rise) begin
        rx <= rx_next;
        if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
      end

      // cs_n is tested as a level: it is only low-to-high here if it rose
      // after the falling edge that opened the frame.
      if ((state inside {CMD, RD_REQ, RD_LOAD, DATA}) && cs_s) begin
        frame_err   <= 1'b1;
        tx          <= '0;
        spi_miso_oe <= 1'b0;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              bit_cnt     <= '0;
              rx          <= '0;
              tx          <= '0;
              is_wr       <= 1'b0;
              spi_miso_oe <= 1'b1;
              state       <= CMD;
            end
          end
          CMD: begin
            if (sclk_rise && (bit_cnt == 5'd7)) begin
              address <= rx_next[5:0];
              is_wr   <= rx_next[7];
              if (rx_next[7]) begin
                state <= DATA;
              end else begin
                read_en <= 1'b1;
                state   <= RD_REQ;
              end
            end
          end
          RD_REQ: state <= RD_LOAD;
          RD_LOAD: begin
            tx    <= rd_data;
            state <= DATA;
          end
          DATA: begin
            if (sclk_rise && (bit_cnt == 5'd15)) begin
              tx <= '0;
              if (is_wr) begin
                write_en <= 1'b1;
                wr_data  <= rx_next;
                state    <= WR_STB;
              end else begin
                state <= DONE;
              end
            end else if (sclk_fall && (bit_cnt >= 5'd9) && (bit_cnt <= 5'd15)) begin
              // Present the next read bit after the host sampled this one
              tx <= {tx[6:0], 1'b0};
            end
          end
          WR_STB: state <= DONE;
          DONE: begin
            tx <= '0;
            if (cs_s) begin
              spi_miso_oe <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
module tb_spi_reg_bridge;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [5:0] address;
  logic       write_en;
  logic [7:0] wr_data;
  logic       read_en;
  logic [7:0] rd_data = 8'h00;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] kind;   // {write_en, read_en, frame_err}
    logic [5:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  logic [7:0] mem [64];

  spi_reg_bridge #(.SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .address     (address),
    .write_en    (write_en),
    .wr_data     (wr_data),
    .read_en     (read_en),
    .rd_data     (rd_data),
    .frame_err   (frame_err)
  );

  always #5 clock = ~clock;

  // Register file model: registered read data, one cycle after read_en
  always @(posedge clock) begin
    if (write_en) mem[address] <= wr_data;
    if (read_en) rd_data <= mem[address];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [5:0] addr, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe the DUT presents is matched against the queue
  always @(negedge clock) begin
    if (reset_n && (write_en || read_en || frame_err)) begin
      check("strobe_exclusive", {15'd0, write_en & read_en}, 16'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe we=%b re=%b fe=%b addr=%h data=%h",
                 write_en, read_en, frame_err, address, wr_data);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_kind", {13'd0, write_en, read_en, frame_err}, {13'd0, e.kind});
        if (e.kind != 3'b001) check("event_addr", {10'd0, address}, {10'd0, e.addr});
        if (e.kind == 3'b100) check("event_wdata", {8'd0, wr_data}, {8'd0, e.data});
      end
    end
  end

  task automatic cs_low();
    spi_cs_n = 1'b0;
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Clock out nbits of word MSB first (zeros beyond 16), sclk = clock/8;
  // MISO is sampled just before each rising edge like a mode-0 host.
  task automatic shift(input logic [15:0] word, input int nbits, output logic [15:0] rxw);
    rxw = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? word[15-i] : 1'b0;
      repeat (4) @(negedge clock);
      rxw = {rxw[14:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (4) @(negedge clock);
      spi_sclk = 1'b0;
    end
    repeat (4) @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rxw;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[5] = 8'hA3;

    repeat (3) @(negedge clock);
    check("rst_address", {10'd0, address}, 16'd0);
    check("rst_wr_data", {8'd0, wr_data}, 16'd0);
    check("rst_write_en", {15'd0, write_en}, 16'd0);
    check("rst_read_en", {15'd0, read_en}, 16'd0);
    check("rst_frame_err", {15'd0, frame_err}, 16'd0);
    check("rst_miso", {15'd0, spi_miso}, 16'd0);
    check("rst_miso_oe", {15'd0, spi_miso_oe}, 16'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // Plain write
    push(3'b100, 6'h0C, 8'h5A);
    cs_low();
    shift(16'h8C5A, 16, rxw);
    check("wr_miso_oe", {15'd0, spi_miso_oe}, 16'd1);
    check("wr_miso_word", rxw, 16'h0000);
    cs_high();
    check("idle_miso_oe", {15'd0, spi_miso_oe}, 16'd0);

    // Read of address 5, register file returns 0xA3
    push(3'b010, 6'h05, 8'h00);
    cs_low();
    shift(16'h0500, 16, rxw);
    check("rd_miso_word", rxw, 16'h00A3);
    cs_high();

    // Write aborted after 12 bits, then a full write
    push(3'b001, 6'h00, 8'h00);
    cs_low();
    shift(16'h8C5A, 12, rxw);
    cs_high();
    check("abort_addr_kept", {10'd0, address}, 16'h000C);
    check("abort_wdata_kept", {8'd0, wr_data}, 16'h005A);
    push(3'b100, 6'h01, 8'hFF);
    cs_low();
    shift(16'h81FF, 16, rxw);
    cs_high();

    // Write followed by 8 extra sclk cycles
    push(3'b100, 6'h1F, 8'h11);
    cs_low();
    shift(16'h9F11, 24, rxw);
    cs_high();
    check("extra_addr_kept", {10'd0, address}, 16'h001F);
    check("extra_wdata_kept", {8'd0, wr_data}, 16'h0011);

    // Reset in the middle of a read frame with cs_n held low
    push(3'b010, 6'h05, 8'h00);
    cs_low();
    shift(16'h0500, 10, rxw);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_address", {10'd0, address}, 16'd0);
    check("midrst_miso_oe", {15'd0, spi_miso_oe}, 16'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    shift(16'hFFFF, 6, rxw);
    check("postrst_miso_word", rxw, 16'h0000);
    check("postrst_address", {10'd0, address}, 16'd0);
    check("postrst_wr_data", {8'd0, wr_data}, 16'd0);
    check("postrst_miso_oe", {15'd0, spi_miso_oe}, 16'd0);
    cs_high();

    // Back-to-back write then read of the same register
    push(3'b100, 6'h04, 8'h3C);
    cs_low();
    shift(16'h843C, 16, rxw);
    cs_high();
    push(3'b010, 6'h04, 8'h00);
    cs_low();
    shift(16'h0400, 16, rxw);
    check("b2b_rd_miso_word", rxw, 16'h003C);
    cs_high();

    repeat (20) @(negedge clock);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
